// File: rtl/dmem_pkg.sv
// Shared encodings, FSM state type and helpers for the byte-addressed data memory controller.
package dmem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  localparam int unsigned DMEM_WAIT_MAX = 15;

  typedef enum logic [1:0] {
    StIdle,
    StWait,
    StResp
  } dmem_state_e;

  // Size 2'b11 is illegal and is reported as a fault like a misalignment.
  function automatic logic bad_access(input logic [1:0] size, input logic [1:0] lane);
    logic bad;
    case (size)
      SZ_BYTE: bad = 1'b0;
      SZ_HALF: bad = lane[0];
      SZ_WORD: bad = |lane;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Little-endian lane steering: load extraction/extension and store merge into the old word.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [1:0]  lane_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] load_o,
  output logic [31:0] store_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;
  logic        ext;

  always_comb begin
    byte_sel = word_i[{lane_i, 3'b000} +: 8];
    half_sel = lane_i[1] ? word_i[31:16] : word_i[15:0];
    ext      = 1'b0;
    load_o   = word_i;
    store_o  = word_i;
    case (size_i)
      SZ_BYTE: begin
        ext                            = ~unsigned_i & byte_sel[7];
        load_o                         = {{24{ext}}, byte_sel};
        store_o[{lane_i, 3'b000} +: 8] = wdata_i[7:0];
      end
      SZ_HALF: begin
        ext    = ~unsigned_i & half_sel[15];
        load_o = {{16{ext}}, half_sel};
        if (lane_i[1]) begin
          store_o[31:16] = wdata_i[15:0];
        end else begin
          store_o[15:0] = wdata_i[15:0];
        end
      end
      SZ_WORD: begin
        store_o = wdata_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/dmem_ctrl.sv
// Byte-addressed data memory with valid/ready handshakes and configurable wait states.
// Optional word-inspection port enabled by defining DMEM_DEBUG_PORT_EN.
module dmem_ctrl
  import dmem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 128,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int unsigned WAIT_CYCLES = 0
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_we,
  input  logic [1:0]                     req_size,
  input  logic                           req_unsigned,
  input  logic [31:0]                    req_addr,
  input  logic [31:0]                    req_wdata,
`ifdef DMEM_DEBUG_PORT_EN
  input  logic [$clog2(DEPTH_WORDS)-1:0] dbg_addr,
  output logic [31:0]                    dbg_data,
`endif
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [31:0]                    rsp_rdata,
  output logic                           rsp_fault
);

  localparam int unsigned AddrW    = $clog2(DEPTH_WORDS);
  localparam int unsigned CntW     = $clog2(DMEM_WAIT_MAX + 1);
  localparam logic [31:0] MemBytes = 32'(DEPTH_WORDS * 4);

  dmem_state_e state_q, state_d;
  logic [CntW-1:0] cnt_q, cnt_d;

  logic        we_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        fault_q, fault_d;

  logic             accept;
  logic             access;
  logic             sel_we;
  logic [1:0]       sel_size;
  logic             sel_uns;
  logic [31:0]      sel_addr;
  logic [31:0]      sel_wdata;
  logic [31:0]      offset;
  logic [AddrW-1:0] idx;
  logic             fault;
  logic [31:0]      rd_word;
  logic [31:0]      load_data;
  logic [31:0]      store_word;

  logic [31:0] mem [DEPTH_WORDS];

  assign req_ready = (state_q == StIdle);
  assign rsp_valid = (state_q == StResp);
  assign rsp_rdata = rdata_q;
  assign rsp_fault = fault_q;
  assign accept    = req_valid && req_ready;

  // With zero wait states the array is accessed on the accept edge from the live request.
  always_comb begin
    if (state_q == StIdle) begin
      sel_we    = req_we;
      sel_size  = req_size;
      sel_uns   = req_unsigned;
      sel_addr  = req_addr;
      sel_wdata = req_wdata;
    end else begin
      sel_we    = we_q;
      sel_size  = size_q;
      sel_uns   = uns_q;
      sel_addr  = addr_q;
      sel_wdata = wdata_q;
    end
  end

  assign offset  = sel_addr - BASE_ADDR;
  assign idx     = offset[AddrW+1:2];
  assign rd_word = mem[idx];
  assign fault   = (offset >= MemBytes) || bad_access(sel_size, offset[1:0]);

  dmem_lane_align u_lane_align (
    .word_i    (rd_word),
    .lane_i    (offset[1:0]),
    .size_i    (sel_size),
    .unsigned_i(sel_uns),
    .wdata_i   (sel_wdata),
    .load_o    (load_data),
    .store_o   (store_word)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    access  = 1'b0;
    rdata_d = rdata_q;
    fault_d = fault_q;
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (WAIT_CYCLES == 0) begin
            state_d = StResp;
            access  = 1'b1;
          end else begin
            state_d = StWait;
            cnt_d   = CntW'(WAIT_CYCLES - 1);
          end
        end
      end
      StWait: begin
        if (cnt_q == '0) begin
          state_d = StResp;
          access  = 1'b1;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      StResp: begin
        if (rsp_ready) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
    if (access) begin
      fault_d = fault;
      rdata_d = (fault || sel_we) ? 32'h0 : load_data;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      rdata_q <= '0;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      fault_q <= fault_d;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_q    <= 1'b0;
      size_q  <= SZ_BYTE;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else if (accept) begin
      we_q    <= req_we;
      size_q  <= req_size;
      uns_q   <= req_unsigned;
      addr_q  <= req_addr;
      wdata_q <= req_wdata;
    end
  end

  // Array is not reset; rst still gates the write so a store can never commit during reset.
  always_ff @(posedge clk) begin
    if (rst && access && sel_we && !fault) begin
      mem[idx] <= store_word;
    end
  end

`ifdef DMEM_DEBUG_PORT_EN
  assign dbg_data = mem[dbg_addr];
`else
  // No inspection window: the array is reachable only through the request port.
`endif

endmodule

// File: doc/dmem_ctrl.md
Name: dmem_ctrl

Overview:
- Byte-addressed, parametrised data memory for the five-stage core's MEM stage; next generation of the word-indexed data RAM.
- Adds lane-correct byte/half access, correct sign extension, misalign/range faults and a configurable wait-state latency.
- Uses a valid/ready request and response handshake so the pipeline stalls instead of assuming single-cycle memory.

Parameters:
- DEPTH_WORDS, 128, number of 32-bit words; power of two.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.
- WAIT_CYCLES, 0, extra cycles between request accept and response (0..15).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  00 byte, 01 half, 10 word; 11 is treated as a fault.
- req_unsigned  in  1  load zero-extends (LBU/LHU) when 1, sign-extends when 0.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned (byte in [7:0], half in [15:0]).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  consumer accepts the response.
- rsp_rdata  out  32  load result, extended; 0 for stores and faults.
- rsp_fault  out  1  misaligned, out-of-range or bad size.

Behaviour:
- Reset (rst=0, async): FSM to IDLE; req_ready=1; rsp_valid=0, rsp_rdata=0, rsp_fault=0; wait counter=0. Memory contents are NOT cleared.
- FSM states:
  - IDLE: req_ready=1. On req_valid&&req_ready, latch we/size/unsigned/addr/wdata. Go to WAIT with counter=WAIT_CYCLES-1, or straight to RESP when WAIT_CYCLES=0.
  - WAIT: req_ready=0; counter decrements each cycle; on the edge where the counter is 0, go to RESP.
  - RESP: rsp_valid=1, req_ready=0. On rsp_ready, go to IDLE. A new request is accepted only from IDLE, so there is at most one outstanding request.
- Latency: rsp_valid rises exactly 1+WAIT_CYCLES cycles after the accept edge.
- Array access (store commit, load capture into rsp_rdata) happens on the edge entering RESP. With WAIT_CYCLES=0 this is the accept edge, using the live request inputs.
- Offset = req_addr - BASE_ADDR; word index = offset[..:2]; lane = offset[1:0]; little-endian.
- Fault if any of:
  - offset >= DEPTH_WORDS*4 (unsigned compare);
  - half with offset[0]=1;
  - word with offset[1:0]!=0;
  - size=11.
- On fault: no array write, rsp_rdata=0, rsp_fault=1.
- Load:
  - byte → lane offset[1:0], extended from bit 7 of that lane;
  - half → bytes offset[1]*2 +: 2, extended from bit 15;
  - word → whole word; req_unsigned ignored.
- Store: only the addressed byte lanes are written; the other lanes are preserved bit-exactly.
- rsp_rdata and rsp_fault are held stable while rsp_valid=1 and rsp_ready=0.
- Reset mid-operation: a store in WAIT is dropped (not committed); a pending response is discarded.
- Unknown state encodings return to IDLE.

Optional Feature:
- Macro DMEM_DEBUG_PORT_EN.
- Defined: adds input dbg_addr [$clog2(DEPTH_WORDS)-1:0] and output dbg_data [31:0], a combinational read of the word at dbg_addr. This is the testbench/board word-inspection window; it has no effect on the FSM.
- Undefined: both ports are absent; behaviour is otherwise identical.

Decomposition:
- Package dmem_pkg holds:
  - size encodings SZ_BYTE/SZ_HALF/SZ_WORD;
  - FSM state typedef (IDLE/WAIT/RESP);
  - DMEM_WAIT_MAX=15.
- One natural sub-module, dmem_lane_align (combinational): load extraction/extension from word+lane+size+unsigned, and store merge producing the new word.

Test Plan:
- WAIT_CYCLES=0: SW 0x12345678 @0x10 then LW @0x10 → rsp_valid 1 cycle after accept, rdata=0x12345678, fault=0.
- Word 0x8070F0FF @0x20: LB @0x20 → 0xFFFFFFFF; LBU @0x23 → 0x00000080; LH @0x22 → 0xFFFF8070; LHU @0x20 → 0x0000F0FF.
- SB 0xAB @0x21 onto 0x11223344 → LW returns 0x1122AB44; SH 0xBEEF @0x22 → 0xBEEFAB44.
- LH @0x21, LW @0x22, SW @BASE_ADDR+DEPTH_WORDS*4 → fault=1, rdata=0, memory unchanged.
- WAIT_CYCLES=3, rsp_ready held 0 for 4 cycles → rsp_valid at accept+4, rdata stable, req_ready=0 until the rsp_ready handshake, then 1.
- WAIT_CYCLES=3: SW then assert rst in WAIT → outputs at reset values immediately; a following LW shows the old word (store dropped).
